// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store unit bridging a request/response port to a byte-lane RAM.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of forcing the offset down.
module lsu_mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ram_en,
    output logic        ram_we,
    output logic [2:0]  ram_mode,
    output logic [1:0]  ram_cs,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic        we_r, uns_r, err_r;
    logic [2:0]  mode_r;
    logic [31:0] addr_r, wdata_r;
    logic        illegal;
    logic [1:0]  cs;
    logic [31:0] wdata_al, rdata_ext;
    logic [15:0] lane_h;
    logic [7:0]  lane_b;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (req_mode[1] && req_addr[0]) || (req_mode[2] && req_addr[1:0] != 2'b00);
    assign illegal  = !(req_mode inside {3'b001, 3'b010, 3'b100}) || misalign;
`else
    assign illegal  = !(req_mode inside {3'b001, 3'b010, 3'b100});
`endif

    // Misaligned offsets are forced down; with the trap enabled they never reach here.
    assign cs        = mode_r[2] ? 2'b00 : mode_r[1] ? {addr_r[1], 1'b0} : addr_r[1:0];
    assign wdata_al  = mode_r[2] ? wdata_r : mode_r[1] ? {2{wdata_r[15:0]}} : {4{wdata_r[7:0]}};
    assign lane_b    = ram_rdata[{cs, 3'b000} +: 8];
    assign lane_h    = cs[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    assign rdata_ext = mode_r[2] ? ram_rdata :
                       mode_r[1] ? {{16{lane_h[15] & ~uns_r}}, lane_h} :
                                   {{24{lane_b[7] & ~uns_r}}, lane_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_valid ? (illegal ? RESP : ACCESS) : IDLE;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = (rsp_valid && rsp_ready) ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = state == IDLE;
        ram_en    = state == ACCESS;
        ram_we    = ram_en && we_r;
        ram_mode  = ram_en ? mode_r : 3'b000;
        ram_cs    = ram_en ? cs : 2'b00;
        ram_addr  = ram_en ? addr_r[31:2] : 30'd0;
        ram_wdata = ram_en ? wdata_al : 32'd0;
    end

    // Read data arrives the cycle after ram_en, so the response registers one cycle into RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r      <= 1'b0;
            uns_r     <= 1'b0;
            err_r     <= 1'b0;
            mode_r    <= 3'b000;
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            if (req_valid && state == IDLE) begin
                we_r    <= req_we;
                uns_r   <= req_unsigned;
                err_r   <= illegal;
                mode_r  <= req_mode;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            if (state == RESP && !rsp_valid) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err_r;
                rsp_rdata <= (we_r || err_r) ? 32'd0 : rdata_ext;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and randomized checks of lsu_mem_ctrl against a lane-arithmetic reference model.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0, rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [2:0]  req_mode;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_en, ram_we;
    logic [2:0]  ram_mode;
    logic [1:0]  ram_cs;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata, rd_word;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int n_cmp = 0, n_bad = 0;
    int o_acc, o_lat, o_busy_rdy, o_hold_bad;
    logic        o_we, o_err, o_after_valid, o_after_ready;
    logic [2:0]  o_mode;
    logic [1:0]  o_cs;
    logic [29:0] o_addr;
    logic [31:0] o_wdata, o_rdata;

    lsu_mem_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_mode(req_mode), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_mode(ram_mode), .ram_cs(ram_cs), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data valid only in the cycle after ram_en, garbage otherwise.
    always @(posedge clk) ram_rdata <= (ram_en && !ram_we) ? rd_word : $urandom;

    function automatic int sz(input logic [2:0] m);
        return m == 3'b100 ? 4 : m == 3'b010 ? 2 : 1;
    endfunction

    function automatic logic m_illegal(input logic [2:0] m, input logic [31:0] a);
        return $countones(m) != 1 || (TRAP && (a % sz(m)) != 0);
    endfunction

    function automatic int m_off(input logic [2:0] m, input logic [31:0] a);
        return (a % 4) - (a % sz(m));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] m, input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = w[(i % sz(m))*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] m, input logic u, input logic [31:0] a, input logic [31:0] rd);
        int s = sz(m);
        logic [31:0] mask, v;
        mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (s*8)) - 32'd1);
        v = (rd >> (m_off(m, a)*8)) & mask;
        if (!u && v[s*8-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic do_req(input logic we, input logic [2:0] mode, input logic uns, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd, input int hold);
        @(negedge clk);
        rd_word = rd; req_valid = 1'b1; req_we = we; req_mode = mode; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
        o_acc = 0; o_lat = 0; o_busy_rdy = 0; o_hold_bad = 0;
        o_we = 1'b0; o_mode = 3'b000; o_cs = 2'b00; o_addr = 30'd0; o_wdata = 32'd0;
        o_rdata = 32'hXXXX_XXXX; o_err = 1'bx; o_after_valid = 1'bx; o_after_ready = 1'bx;
        @(posedge clk);
        for (int k = 1; k <= 12 && o_lat == 0; k++) begin
            @(negedge clk);
            req_valid = 1'($urandom_range(0, 1));
            if (req_ready) o_busy_rdy++;
            if (ram_en) begin
                o_acc++; o_we = ram_we; o_mode = ram_mode; o_cs = ram_cs; o_addr = ram_addr; o_wdata = ram_wdata;
            end
            if (rsp_valid) begin
                o_lat = k; o_rdata = rsp_rdata; o_err = rsp_err;
            end
        end
        if (o_lat != 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!rsp_valid || req_ready || ram_en || rsp_rdata !== o_rdata || rsp_err !== o_err) o_hold_bad++;
            end
            req_valid = 1'b0; rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0; o_after_valid = rsp_valid; o_after_ready = req_ready;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mode = 3'b000; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0; rd_word = 32'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, ram_en, ram_we, ram_mode, ram_cs, ram_addr, ram_wdata} !==
            {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0, 30'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset: rdy=%b vld=%b err=%b rdata=%h en=%b we=%b mode=%b cs=%b addr=%h wd=%h, want rdy=1 and rest 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, ram_en, ram_we, ram_mode, ram_cs, ram_addr, ram_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_word();
        do_req(1'b1, 3'b100, 1'b0, 32'h100, 32'hDEADBEEF, $urandom, 0);
        n_cmp++;
        if ({o_acc[1:0], o_we, o_mode, o_cs, o_addr, o_wdata} !== {2'd1, 1'b1, 3'b100, 2'b00, 30'h40, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL store_word_ram: acc=%0d we=%b mode=%b cs=%b addr=%h wd=%h want 1 1 100 00 40 deadbeef",
                     o_acc, o_we, o_mode, o_cs, o_addr, o_wdata);
        end
        n_cmp++;
        if ({o_lat[3:0], o_rdata, o_err} !== {4'd3, 32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL store_word_rsp: lat=%0d rdata=%h err=%b want 3 00000000 0", o_lat, o_rdata, o_err);
        end
    endtask

    task automatic test_load_byte();
        do_req(1'b0, 3'b001, 1'b0, 32'h103, $urandom, 32'h80FF1234, 0);
        n_cmp++;
        if ({o_lat[3:0], o_rdata, o_err, o_cs} !== {4'd3, 32'hFFFFFF80, 1'b0, 2'b11}) begin
            n_bad++;
            $display("FAIL load_byte_signed: lat=%0d rdata=%h err=%b cs=%b want 3 ffffff80 0 11", o_lat, o_rdata, o_err, o_cs);
        end
        do_req(1'b0, 3'b001, 1'b1, 32'h103, $urandom, 32'h80FF1234, 0);
        n_cmp++;
        if ({o_lat[3:0], o_rdata, o_err} !== {4'd3, 32'h00000080, 1'b0}) begin
            n_bad++;
            $display("FAIL load_byte_unsigned: lat=%0d rdata=%h err=%b want 3 00000080 0", o_lat, o_rdata, o_err);
        end
    endtask

    task automatic test_store_half();
        do_req(1'b1, 3'b010, 1'b0, 32'h102, 32'h0000ABCD, $urandom, 0);
        n_cmp++;
        if ({o_acc[1:0], o_we, o_mode, o_cs, o_addr, o_wdata} !== {2'd1, 1'b1, 3'b010, 2'b10, 30'h40, 32'hABCDABCD}) begin
            n_bad++;
            $display("FAIL store_half: acc=%0d we=%b mode=%b cs=%b addr=%h wd=%h want 1 1 010 10 40 abcdabcd",
                     o_acc, o_we, o_mode, o_cs, o_addr, o_wdata);
        end
    endtask

    task automatic test_misalign();
        do_req(1'b0, 3'b100, 1'b0, 32'h101, $urandom, 32'h11223344, 0);
        n_cmp++;
        if ({o_acc[1:0], o_lat[3:0], o_err, o_cs} !== {TRAP ? 2'd0 : 2'd1, TRAP ? 4'd2 : 4'd3, TRAP, 2'b00}) begin
            n_bad++;
            $display("FAIL misalign_word: acc=%0d lat=%0d err=%b cs=%b trap=%b", o_acc, o_lat, o_err, o_cs, TRAP);
        end
        n_cmp++;
        if (o_rdata !== (TRAP ? 32'd0 : 32'h11223344)) begin
            n_bad++;
            $display("FAIL misalign_rdata: got %h trap=%b", o_rdata, TRAP);
        end
    endtask

    task automatic test_error_hold();
        do_req(1'b0, 3'b011, 1'b0, 32'h200, $urandom, $urandom, 3);
        n_cmp++;
        if ({o_acc[1:0], o_lat[3:0], o_err, o_rdata} !== {2'd0, 4'd2, 1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL bad_mode: acc=%0d lat=%0d err=%b rdata=%h want 0 2 1 00000000", o_acc, o_lat, o_err, o_rdata);
        end
        n_cmp++;
        if ({o_hold_bad[3:0], o_busy_rdy[3:0], o_after_valid, o_after_ready} !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL bad_mode_hold: hold_bad=%0d busy_rdy=%0d after_vld=%b after_rdy=%b want 0 0 0 1",
                     o_hold_bad, o_busy_rdy, o_after_valid, o_after_ready);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            logic        we, uns, ill;
            logic [2:0]  mode;
            logic [31:0] addr, wdata, rd, exp_rd;
            int          hold;
            we = 1'($urandom); uns = 1'($urandom);
            mode = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b001 << $urandom_range(0, 2);
            addr = $urandom; wdata = $urandom; rd = $urandom; hold = $urandom_range(0, 2);
            ill = m_illegal(mode, addr);
            exp_rd = (we || ill) ? 32'd0 : m_rdata(mode, uns, addr, rd);
            do_req(we, mode, uns, addr, wdata, rd, hold);
            n_cmp++;
            if ({o_acc[1:0], o_lat[3:0], o_err, o_rdata} !== {ill ? 2'd0 : 2'd1, ill ? 4'd2 : 4'd3, ill, exp_rd}) begin
                n_bad++;
                $display("FAIL rand_rsp[%0d]: we=%b mode=%b u=%b addr=%h rd=%h got acc=%0d lat=%0d err=%b rdata=%h want acc=%0d lat=%0d err=%b rdata=%h",
                         i, we, mode, uns, addr, rd, o_acc, o_lat, o_err, o_rdata, ill ? 0 : 1, ill ? 2 : 3, ill, exp_rd);
            end
            if (!ill) begin
                n_cmp++;
                if ({o_we, o_mode, o_cs, o_addr} !== {we, mode, 2'(m_off(mode, addr)), addr[31:2]} ||
                    (we && o_wdata !== m_wdata(mode, wdata))) begin
                    n_bad++;
                    $display("FAIL rand_ram[%0d]: got we=%b mode=%b cs=%b addr=%h wd=%h want we=%b mode=%b cs=%0d addr=%h wd=%h",
                             i, o_we, o_mode, o_cs, o_addr, o_wdata, we, mode, m_off(mode, addr), addr[31:2], m_wdata(mode, wdata));
                end
            end
            n_cmp++;
            if ({o_busy_rdy[3:0], o_hold_bad[3:0], o_after_valid, o_after_ready} !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL rand_flow[%0d]: busy_rdy=%0d hold_bad=%0d after_vld=%b after_rdy=%b want 0 0 0 1",
                         i, o_busy_rdy, o_hold_bad, o_after_valid, o_after_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(negedge clk);
        rd_word = $urandom; req_valid = 1'b1; req_we = 1'b0; req_mode = 3'b100; req_addr = 32'h40; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (ram_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_access: ram_en=%b want 1", ram_en);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_en, ram_we, rsp_valid, req_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_mid_drop: en=%b we=%b vld=%b rdy=%b want 0 0 0 1", ram_en, ram_we, rsp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || ram_en || !req_ready) bad++;
        end
        rsp_ready = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL rst_mid_after: %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_error_hold();
        test_random();
        test_reset_mid();
        test_store_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
